// File: rtl/allstub_read_arbiter_if.sv
// allstub_read_arbiter_if
// Groups the arbiter's control, requester and memory-side signals.
//   start/done      : [0] new-BX pulse, [1] pipelined reset; done is start delayed
//   req/req_add/gnt : per-requester request, stub address slices, one-hot grant
//   read_add        : {page, addr} to the AllStubs memory read port
//   data_in         : memory read data
//   data_out/valid_out/id_out : returned data tagged with the owning requester
// Modports: slave = arbiter view, master = environment view.
interface allstub_read_arbiter_if #(
    parameter int NREQ     = 4,
    parameter int ID_W     = 2,
    parameter int MEM_SIZE = 6,
    parameter int BX_BITS  = 5
);
    logic [1:0]                  start;
    logic [1:0]                  done;
    logic [NREQ-1:0]             req;
    logic [NREQ*MEM_SIZE-1:0]    req_add;
    logic [NREQ-1:0]             gnt;
    logic [BX_BITS+MEM_SIZE-1:0] read_add;
    logic [35:0]                 data_in;
    logic [35:0]                 data_out;
    logic                        valid_out;
    logic [ID_W-1:0]             id_out;

    modport slave (
        input  start, req, req_add, data_in,
        output done, gnt, read_add, data_out, valid_out, id_out
    );

    modport master (
        output start, req, req_add, data_in,
        input  done, gnt, read_add, data_out, valid_out, id_out
    );
endinterface

// File: rtl/allstub_read_arbiter.sv
// allstub_read_arbiter
// Round-robin sharing of one AllStubs memory read port among NREQ consumers.
// Forms the {page, addr} read address from a BX counter advanced by start[0],
// and returns each read's data tagged with the requester ID.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : allstub_read_arbiter_if.slave (start/done, req/req_add/gnt,
//           read_add, data_in, data_out/valid_out/id_out)
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_WAIT   | idle after reset / start[1]; no grants until start[0]
// S_RUN    | arbitrating one request per cycle
// S_SWITCH | one-cycle gap after start[0] while the page changes
module allstub_read_arbiter #(
    parameter int NREQ       = 4,
    parameter int ID_W       = 2,
    parameter int MEM_SIZE   = 6,
    parameter int BX_BITS    = 5,
    parameter int RD_LATENCY = 2,
    parameter int BX_OFFSET  = 1,
    parameter int DONE_DLY   = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    allstub_read_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_RUN    = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        w_rst;
    logic                        w_arb_en;
    logic                        w_gnt_any;
    logic                        w_grant;
    logic [ID_W-1:0]             w_gnt_idx;
    logic [NREQ-1:0]             w_gnt;
    logic [BX_BITS-1:0]          w_page;

    logic [BX_BITS-1:0]          r_bx_cnt;
    logic [ID_W-1:0]             r_rr_ptr;
    logic [BX_BITS+MEM_SIZE-1:0] r_read_add;
    logic                        r_vld_pipe [RD_LATENCY+1];
    logic [ID_W-1:0]             r_id_pipe  [RD_LATENCY+1];
    logic                        r_valid_out;
    logic [ID_W-1:0]             r_id_out;
    logic [35:0]                 r_data_out;
    logic [1:0]                  r_done_pipe [DONE_DLY];

    // start[1] acts as a pipelined reset for everything except the done chain
    assign w_rst  = reset | bus.start[1];
    assign w_page = r_bx_cnt - BX_BITS'(BX_OFFSET);

    // Rotating priority search starting at r_rr_ptr
    always_comb begin
        logic [ID_W-1:0] v_idx;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        v_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            v_idx = ID_W'((int'(r_rr_ptr) + i) % NREQ);
            if (!w_gnt_any && bus.req[v_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = v_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arb_en    = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (bus.start[0]) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_arb_en = ~bus.start[0];
                if (bus.start[0]) w_state_nxt = S_SWITCH;
            end
            S_SWITCH: begin
                if (!bus.start[0]) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_WAIT;
        endcase
        if (w_rst) begin
            w_state_nxt = S_WAIT;
            w_arb_en    = 1'b0;
        end
    end

    assign w_grant = w_arb_en & w_gnt_any;
    assign w_gnt   = w_grant ? (NREQ'(1) << w_gnt_idx) : '0;

    always_ff @(posedge clk) begin
        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_bx_cnt    <= '1;
            r_rr_ptr    <= '0;
            r_read_add  <= '0;
            r_valid_out <= 1'b0;
            r_id_out    <= '0;
            r_data_out  <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) begin
                r_vld_pipe[i] <= 1'b0;
                r_id_pipe[i]  <= '0;
            end
        end else begin
            if (bus.start[0]) r_bx_cnt <= r_bx_cnt + 1'b1;
            if (w_grant) begin
                r_rr_ptr   <= (w_gnt_idx == ID_W'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
                r_read_add <= {w_page, bus.req_add[w_gnt_idx*MEM_SIZE +: MEM_SIZE]};
            end
            // Stage 0 lines up with read_add; stage RD_LATENCY lines up with data_in
            r_vld_pipe[0] <= w_grant;
            r_id_pipe[0]  <= w_gnt_idx;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_id_pipe[i]  <= r_id_pipe[i-1];
            end
            r_valid_out <= r_vld_pipe[RD_LATENCY];
            r_id_out    <= r_id_pipe[RD_LATENCY];
            r_data_out  <= bus.data_in;
        end
    end

    // Only the hard reset clears done so that start[1] still reaches done[1]
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DONE_DLY; i++) r_done_pipe[i] <= 2'b00;
        end else begin
            r_done_pipe[0] <= bus.start;
            for (int i = 1; i < DONE_DLY; i++) r_done_pipe[i] <= r_done_pipe[i-1];
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.read_add  = r_read_add;
    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign bus.id_out    = r_id_out;
    assign bus.done      = r_done_pipe[DONE_DLY-1];

endmodule

// File: tb/tb_allstub_read_arbiter.sv
module tb_allstub_read_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    allstub_read_arbiter_if bus ();

    allstub_read_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic chk_en = 1'b0;

    logic [4:0]  m_bx = 5'd31;
    logic [5:0]  ra [4] = '{6'd5, 6'd11, 6'd12, 6'd13};
    logic        exp_v [2048];
    logic [1:0]  exp_i [2048];
    logic [35:0] exp_d [2048];
    logic [1:0]  st_hist [2048];

    // Memory model: read_add -> data_in with two cycles of latency
    logic [10:0] mem_a1 = '0;
    initial bus.data_in = '0;
    always @(posedge clk) begin
        mem_a1      <= bus.read_add;
        bus.data_in <= {25'b0, mem_a1};
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            #2;
            chk("valid_out", 64'(bus.valid_out), 64'(exp_v[cyc]));
            if (exp_v[cyc]) begin
                chk("id_out", 64'(bus.id_out), 64'(exp_i[cyc]));
                chk("data_out", 64'(bus.data_out), 64'(exp_d[cyc]));
            end
            chk("done", 64'(bus.done), (cyc >= 6) ? 64'(st_hist[cyc-6]) : 64'd0);
        end
    end

    // One cycle: apply start/req, check gnt, schedule the expected return
    task automatic cyc_t(input logic [1:0] st, input logic [3:0] rq, input logic [3:0] eg);
        logic [4:0] pg;
        int n;
        @(negedge clk);
        bus.start = st;
        bus.req   = rq;
        n = cyc;
        st_hist[n] = st;
        #1;
        chk("gnt", 64'(bus.gnt), 64'(eg));
        pg = m_bx - 5'd1;
        for (int k = 0; k < 4; k++) begin
            if (eg[k]) begin
                exp_v[n+4] = 1'b1;
                exp_i[n+4] = 2'(k);
                exp_d[n+4] = {25'b0, pg, ra[k]};
            end
        end
        if (st[1]) begin
            for (int j = 1; j <= 4; j++) exp_v[n+j] = 1'b0;
            m_bx = 5'd31;
        end else if (st[0]) begin
            m_bx = m_bx + 5'd1;
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            exp_v[i]   = 1'b0;
            exp_i[i]   = '0;
            exp_d[i]   = '0;
            st_hist[i] = 2'b00;
        end
        bus.start   = 2'b00;
        bus.req     = 4'b1111;
        bus.req_add = {6'd13, 6'd12, 6'd11, 6'd5};

        // Reset
        repeat (2) @(negedge clk);
        #1;
        chk("gnt_in_reset", 64'(bus.gnt), 64'd0);
        @(negedge clk);
        reset   = 1'b0;
        bus.req = 4'b0000;
        #1;
        chk("rst_read_add", 64'(bus.read_add), 64'd0);
        chk("rst_valid", 64'(bus.valid_out), 64'd0);
        chk("rst_id", 64'(bus.id_out), 64'd0);
        chk("rst_data", 64'(bus.data_out), 64'd0);
        chk_en = 1'b1;

        // 1: first read after start, page 31 (bx 0 minus offset 1)
        cyc_t(2'b00, 4'b0001, 4'b0000);
        cyc_t(2'b01, 4'b0001, 4'b0000);
        cyc_t(2'b00, 4'b0001, 4'b0001);
        cyc_t(2'b00, 4'b0000, 4'b0000);
        chk("read_add_t1", 64'(bus.read_add), 64'({5'd31, 6'd5}));
        repeat (4) cyc_t(2'b00, 4'b0000, 4'b0000);
        chk("read_add_hold", 64'(bus.read_add), 64'({5'd31, 6'd5}));

        // 2: continuous requests rotate from rr_ptr = 1
        cyc_t(2'b00, 4'b1111, 4'b0010);
        cyc_t(2'b00, 4'b1111, 4'b0100);
        cyc_t(2'b00, 4'b1111, 4'b1000);
        cyc_t(2'b00, 4'b1111, 4'b0001);
        cyc_t(2'b00, 4'b1111, 4'b0010);

        // 3: start[0] during traffic, plus start[0] while in SWITCH
        cyc_t(2'b00, 4'b1111, 4'b0100);
        cyc_t(2'b01, 4'b1111, 4'b0000);
        cyc_t(2'b00, 4'b1111, 4'b0000);
        cyc_t(2'b00, 4'b1111, 4'b1000);
        cyc_t(2'b00, 4'b1111, 4'b0001);
        cyc_t(2'b01, 4'b1111, 4'b0000);
        cyc_t(2'b01, 4'b1111, 4'b0000);
        cyc_t(2'b00, 4'b1111, 4'b0000);
        cyc_t(2'b00, 4'b1111, 4'b0010);

        // 4: start[1] with three reads in flight; start[1] beats start[0]
        cyc_t(2'b00, 4'b1111, 4'b0100);
        cyc_t(2'b00, 4'b1111, 4'b1000);
        cyc_t(2'b00, 4'b1111, 4'b0001);
        cyc_t(2'b10, 4'b1111, 4'b0000);
        repeat (3) cyc_t(2'b00, 4'b1111, 4'b0000);
        cyc_t(2'b11, 4'b1111, 4'b0000);
        cyc_t(2'b00, 4'b1111, 4'b0000);
        cyc_t(2'b01, 4'b1111, 4'b0000);
        cyc_t(2'b00, 4'b1111, 4'b0001);
        repeat (5) cyc_t(2'b00, 4'b0000, 4'b0000);

        // 5: 33 BX pulses, one read per BX to observe the page wrap
        for (int p = 0; p < 33; p++) begin
            cyc_t(2'b01, 4'b0000, 4'b0000);
            cyc_t(2'b00, 4'b0000, 4'b0000);
            cyc_t(2'b00, 4'b0001, 4'b0001);
        end
        repeat (5) cyc_t(2'b00, 4'b0000, 4'b0000);

        // 6: wrap-around search from rr_ptr = 3
        cyc_t(2'b00, 4'b0100, 4'b0100);
        cyc_t(2'b00, 4'b0100, 4'b0100);
        cyc_t(2'b00, 4'b1111, 4'b1000);
        repeat (7) cyc_t(2'b00, 4'b0000, 4'b0000);

        chk_en = 1'b0;
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
